ifu_axi_fetch: RTL and testbench
================================

Name: ifu_axi_fetch

Overview:
- Instruction fetch unit of the RV32I pipeline.
- Acts as an AXI4 read initiator toward instruction memory.
- Produces the pc/inst/valid stream that the decode stage consumes, honouring the decode stage's stall.
- Accepts branch/jump redirects from execute and discards fetches that are already in flight when a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant value driven on o_arid.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- i_stall  in  1  decode stall; hold the output stage
- i_redirect  in  1  taken branch/jal/jalr; flush the fetch stream
- i_redirect_pc  in  32  redirect target
- o_pc  out  32  pc of o_inst
- o_inst  out  32  fetched instruction
- o_valid_inst  out  1  o_pc/o_inst hold a live instruction
- o_arid  out  ID_W  constant AXI_ID
- o_araddr  out  32  fetch address
- o_arlen  out  8  constant 0 (single beat)
- o_arsize  out  3  constant 3'b010
- o_arburst  out  2  constant 2'b01 (INCR)
- o_arvalid  out  1  AR valid
- i_arready  in  1  AR ready
- i_rdata  in  32  R data
- i_rresp  in  2  R response
- i_rlast  in  1  R last
- i_rvalid  in  1  R valid
- o_rready  out  1  R ready

Behaviour:
- Reset values: o_pc=0, o_inst=0, o_valid_inst=0, o_arvalid=0, o_araddr=RESET_PC, fetch_pc=RESET_PC, drop=0, state=REQ. Reset aborts any transaction mid-flight.
- At most one outstanding read at any time.
- FSM state REQ:
  - o_arvalid=1, o_araddr=fetch_pc.
  - On i_arready go to RESP.
  - Once asserted, o_arvalid and o_araddr stay stable until the handshake (AXI rule), even if a redirect arrives.
- FSM state RESP:
  - o_rready = !o_valid_inst || !i_stall.
  - On i_rvalid && o_rready && i_rlast, go to REQ.
  - If drop=1: discard the beat, clear drop, leave fetch_pc unchanged (it already holds the redirect target).
  - If drop=0: o_inst<=i_rdata, o_pc<=fetch_pc, o_valid_inst<=1, fetch_pc<=fetch_pc+4.
- Output stage:
  - When o_valid_inst && !i_stall and no new capture, o_valid_inst<=0.
  - While i_stall=1, o_pc and o_inst are frozen.
- Redirect:
  - fetch_pc<={i_redirect_pc[31:2],2'b00}.
  - o_valid_inst<=0 next cycle.
  - drop<=1 if an AR is pending (o_arvalid && !i_arready) or a response is outstanding (state RESP).
  - An R beat accepted in the same cycle as the redirect is discarded.
  - Redirect overrides i_stall.
- Redirect while REQ has o_arvalid=1:
  - Address stays stable and drop is set.
  - After the discarded beat, the next REQ uses the redirect target.
- i_rresp != 2'b00: the beat is delivered as a NOP (o_inst=32'h0000_0013) with the correct o_pc, and the pc still advances.
- Wrap-around: fetch_pc 32'hFFFF_FFFC +4 -> 32'h0000_0000.
- Latency:
  - AR issued the first cycle after reset deassert.
  - o_valid_inst rises the cycle after the R handshake.
  - Best-case throughput is one instruction per 2 cycles.
- Back-pressure: no R beat is accepted while the output stage holds a stalled live instruction.

Optional Feature:
- Macro: IFU_STAT_EN.
- When defined:
  - Adds ports o_fetch_cnt (out, 32) and o_drop_cnt (out, 32).
  - o_fetch_cnt increments on every delivered instruction (o_valid_inst rising or refilled).
  - o_drop_cnt increments on every discarded R beat.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory with zero-wait arready and rvalid one cycle after AR:
  - araddr sequence 0x0, 0x4, 0x8.
  - o_inst matches memory, o_pc 0x0/0x4/0x8, o_valid_inst pulses.
- i_stall=1 for 5 cycles while o_valid_inst=1 at pc 0x8:
  - o_rready=0, o_pc/o_inst frozen.
  - Next instruction at 0xC delivered only after stall drops.
- i_redirect to 0x100 while AR to 0x10 is pending with arready low for 3 cycles:
  - araddr stays 0x10 until the handshake and that beat is discarded.
  - Next araddr is 0x100, next o_pc is 0x100.
- i_redirect to 0x203 in the same cycle as an R beat:
  - Beat dropped, next fetch at 0x200.
- i_rresp=2'b10 on fetch at 0x20:
  - o_inst=32'h0000_0013, o_pc=0x20, next fetch 0x24.
- RESET_PC=32'hFFFF_FFFC:
  - Fetches 0xFFFF_FFFC then 0x0.
  - Assert rst during RESP: all outputs return to reset values immediately.

Source files
------------

// File: rtl/ifu_axi_fetch.sv
// RV32I instruction fetch unit: single-outstanding AXI4 read initiator feeding decode.
// Define IFU_STAT_EN to add fetch/drop statistics counters (o_fetch_cnt, o_drop_cnt).
module ifu_axi_fetch #(
    parameter logic [31:0]     RESET_PC = 32'h0000_0000,
    parameter int unsigned     ID_W     = 4,
    parameter logic [ID_W-1:0] AXI_ID   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [31:0]     i_redirect_pc,
    output logic [31:0]     o_pc,
    output logic [31:0]     o_inst,
    output logic            o_valid_inst,
    output logic [ID_W-1:0] o_arid,
    output logic [31:0]     o_araddr,
    output logic [7:0]      o_arlen,
    output logic [2:0]      o_arsize,
    output logic [1:0]      o_arburst,
    output logic            o_arvalid,
    input  logic            i_arready,
    input  logic [31:0]     i_rdata,
    input  logic [1:0]      i_rresp,
    input  logic            i_rlast,
    input  logic            i_rvalid,
    output logic            o_rready
`ifdef IFU_STAT_EN
    ,
    output logic [31:0]     o_fetch_cnt,
    output logic [31:0]     o_drop_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {StReq, StResp} state_e;

    state_e      state;
    logic [31:0] fetch_pc;
    logic        drop;
    logic        beat, done, discard, capture;
    logic [31:0] redir_pc, next_pc;
    logic        unused_redir_lsbs;

    assign o_arid    = AXI_ID;
    assign o_arlen   = 8'd0;
    assign o_arsize  = 3'b010;
    assign o_arburst = 2'b01;

    assign o_rready = (state == StResp) && (!o_valid_inst || !i_stall);
    assign beat     = (state == StResp) && i_rvalid && o_rready;
    assign done     = beat && i_rlast;
    // A beat is stale if a redirect came earlier (drop) or arrives this very cycle.
    assign discard  = beat && (drop || i_redirect);
    assign capture  = beat && !discard;
    assign redir_pc = {i_redirect_pc[31:2], 2'b00};
    assign unused_redir_lsbs = ^i_redirect_pc[1:0];

    always_comb begin
        next_pc = fetch_pc;
        if (i_redirect) begin
            next_pc = redir_pc;
        end else if (capture) begin
            next_pc = fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StReq;
            fetch_pc     <= RESET_PC;
            drop         <= 1'b0;
            o_pc         <= 32'd0;
            o_inst       <= 32'd0;
            o_valid_inst <= 1'b0;
            o_arvalid    <= 1'b0;
            o_araddr     <= RESET_PC;
        end else begin
            fetch_pc <= next_pc;

            if (capture) begin
                o_pc   <= fetch_pc;
                o_inst <= (i_rresp == 2'b00) ? i_rdata : NOP;
            end

            if (i_redirect) begin
                o_valid_inst <= 1'b0;
            end else if (capture) begin
                o_valid_inst <= 1'b1;
            end else if (!i_stall) begin
                o_valid_inst <= 1'b0;
            end

            case (state)
                StReq: begin
                    // Address is held once valid is up; a redirect only marks the reply stale.
                    if (!o_arvalid) begin
                        o_arvalid <= 1'b1;
                        o_araddr  <= next_pc;
                    end else if (i_arready) begin
                        o_arvalid <= 1'b0;
                        state     <= StResp;
                    end
                    if (i_redirect && o_arvalid) begin
                        drop <= 1'b1;
                    end
                end
                StResp: begin
                    if (done) begin
                        state     <= StReq;
                        o_arvalid <= 1'b1;
                        o_araddr  <= next_pc;
                        drop      <= 1'b0;
                    end else if (i_redirect) begin
                        drop <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef IFU_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_fetch_cnt <= 32'd0;
            o_drop_cnt  <= 32'd0;
        end else begin
            if (capture) begin
                o_fetch_cnt <= o_fetch_cnt + 32'd1;
            end
            if (discard) begin
                o_drop_cnt <= o_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Directed bench for ifu_axi_fetch: one DUT at RESET_PC=0, one at RESET_PC=0xFFFF_FFFC.
module tb_ifu_axi_fetch;

    logic clk, rst, rst_b;

    // DUT A
    logic        stall_a, redirect_a;
    logic [31:0] redirect_pc_a;
    logic [31:0] pc_a, inst_a, araddr_a, rdata_a;
    logic        valid_a, arvalid_a, arready_a, rvalid_a, rready_a;
    logic [3:0]  arid_a;
    logic [7:0]  arlen_a;
    logic [2:0]  arsize_a;
    logic [1:0]  arburst_a, rresp_a;
    logic        rlast;

    // DUT B
    logic        stall_b, redirect_b;
    logic [31:0] redirect_pc_b;
    logic [31:0] pc_b, inst_b, araddr_b, rdata_b;
    logic        valid_b, arvalid_b, arready_b, rvalid_b, rready_b;
    logic [3:0]  arid_b;
    logic [7:0]  arlen_b;
    logic [2:0]  arsize_b;
    logic [1:0]  arburst_b, rresp_b;

`ifdef IFU_STAT_EN
    logic [31:0] fetch_cnt_a, drop_cnt_a, fetch_cnt_b, drop_cnt_b;
`endif

    int          n_vec, n_err;
    int          ar_wait;
    logic        pend_a, pend_b;
    logic [31:0] addr_a, addr_b;
    logic [31:0] ar_log[$];
    logic [31:0] exp_log[11];

    ifu_axi_fetch #(.RESET_PC(32'h0000_0000), .ID_W(4), .AXI_ID(4'd0)) u_dut_a (
        .clk(clk), .rst(rst), .i_stall(stall_a), .i_redirect(redirect_a),
        .i_redirect_pc(redirect_pc_a), .o_pc(pc_a), .o_inst(inst_a), .o_valid_inst(valid_a),
        .o_arid(arid_a), .o_araddr(araddr_a), .o_arlen(arlen_a), .o_arsize(arsize_a),
        .o_arburst(arburst_a), .o_arvalid(arvalid_a), .i_arready(arready_a),
        .i_rdata(rdata_a), .i_rresp(rresp_a), .i_rlast(rlast), .i_rvalid(rvalid_a),
        .o_rready(rready_a)
`ifdef IFU_STAT_EN
        , .o_fetch_cnt(fetch_cnt_a), .o_drop_cnt(drop_cnt_a)
`endif
    );

    ifu_axi_fetch #(.RESET_PC(32'hFFFF_FFFC), .ID_W(4), .AXI_ID(4'd0)) u_dut_b (
        .clk(clk), .rst(rst_b), .i_stall(stall_b), .i_redirect(redirect_b),
        .i_redirect_pc(redirect_pc_b), .o_pc(pc_b), .o_inst(inst_b), .o_valid_inst(valid_b),
        .o_arid(arid_b), .o_araddr(araddr_b), .o_arlen(arlen_b), .o_arsize(arsize_b),
        .o_arburst(arburst_b), .o_arvalid(arvalid_b), .i_arready(arready_b),
        .i_rdata(rdata_b), .i_rresp(rresp_b), .i_rlast(rlast), .i_rvalid(rvalid_b),
        .o_rready(rready_b)
`ifdef IFU_STAT_EN
        , .o_fetch_cnt(fetch_cnt_b), .o_drop_cnt(drop_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory responses driven on the falling edge, handshakes recorded at the rise.
    // Memory word at address a is {16'hC0DE, a[15:0]}; address 0x20 answers SLVERR.
    task automatic tick();
        logic ar_fire_a, r_fire_a, ar_fire_b, r_fire_b;
        logic [31:0] aa, ab;
        @(negedge clk);
        if (ar_wait > 0 && arvalid_a) begin
            arready_a = 1'b0;
            ar_wait--;
        end else begin
            arready_a = 1'b1;
        end
        rvalid_a = pend_a;
        rdata_a  = {16'hC0DE, addr_a[15:0]};
        rresp_a  = (pend_a && addr_a == 32'h20) ? 2'b10 : 2'b00;
        if (rst_b) pend_b = 1'b0;
        arready_b = 1'b1;
        rvalid_b  = pend_b;
        rdata_b   = {16'hC0DE, addr_b[15:0]};
        rresp_b   = 2'b00;
        #1;
        ar_fire_a = arvalid_a && arready_a;
        r_fire_a  = rvalid_a && rready_a;
        ar_fire_b = arvalid_b && arready_b;
        r_fire_b  = rvalid_b && rready_b;
        aa = araddr_a;
        ab = araddr_b;
        @(posedge clk);
        if (r_fire_a) pend_a = 1'b0;
        if (ar_fire_a) begin
            pend_a = 1'b1;
            addr_a = aa;
            ar_log.push_back(aa);
        end
        if (r_fire_b) pend_b = 1'b0;
        if (ar_fire_b) begin
            pend_b = 1'b1;
            addr_b = ab;
        end
        #1;
    endtask

    task automatic stall_checks();
        check("stall_rready", {31'd0, rready_a}, 32'd0);
        check("stall_pc", pc_a, 32'h8);
        check("stall_inst", inst_a, 32'hC0DE_0008);
        check("stall_valid", {31'd0, valid_a}, 32'd1);
    endtask

    initial begin
        n_vec = 0; n_err = 0; ar_wait = 0;
        pend_a = 0; pend_b = 0; addr_a = 0; addr_b = 0;
        rst = 1; rst_b = 1; rlast = 1;
        stall_a = 0; redirect_a = 0; redirect_pc_a = 0;
        stall_b = 0; redirect_b = 0; redirect_pc_b = 0;
        arready_a = 1; rvalid_a = 0; rdata_a = 0; rresp_a = 0;
        arready_b = 1; rvalid_b = 0; rdata_b = 0; rresp_b = 0;
        exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104,
                    32'h200, 32'h204, 32'h20, 32'h24};

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc_a, 32'h0);
        check("rst_inst", inst_a, 32'h0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_arvalid", {31'd0, arvalid_a}, 32'd0);
        check("rst_araddr", araddr_a, 32'h0);
        check("rst_araddr_b", araddr_b, 32'hFFFF_FFFC);
        check("arid", {28'd0, arid_a}, 32'd0);
        check("arlen", {24'd0, arlen_a}, 32'd0);
        check("arsize", {29'd0, arsize_a}, 32'd2);
        check("arburst", {30'd0, arburst_a}, 32'd1);

        rst = 0; rst_b = 0;
        tick();                                    // 1: AR raised
        check("ar_first_valid", {31'd0, arvalid_a}, 32'd1);
        check("ar_first_addr", araddr_a, 32'h0);
        check("b_ar_first_addr", araddr_b, 32'hFFFF_FFFC);
        tick();                                    // 2: AR handshake
        tick();                                    // 3: R handshake
        check("d0_valid", {31'd0, valid_a}, 32'd1);
        check("d0_pc", pc_a, 32'h0);
        check("d0_inst", inst_a, 32'hC0DE_0000);
        check("b_d0_pc", pc_b, 32'hFFFF_FFFC);
        check("b_d0_inst", inst_b, 32'hC0DE_FFFC);
        tick();                                    // 4
        check("d0_pulse", {31'd0, valid_a}, 32'd0);
        tick();                                    // 5
        check("d1_pc", pc_a, 32'h4);
        check("d1_inst", inst_a, 32'hC0DE_0004);
        check("b_wrap_pc", pc_b, 32'h0);
        check("b_wrap_inst", inst_b, 32'hC0DE_0000);
        check("b_wrap_valid", {31'd0, valid_b}, 32'd1);
        tick();                                    // 6
        tick();                                    // 7
        check("d2_pc", pc_a, 32'h8);
        check("d2_valid", {31'd0, valid_a}, 32'd1);

        stall_a = 1; stall_b = 1;
        tick();                                    // 8: B now in RESP with a live word
        stall_checks();
        rst_b = 1; stall_b = 0;
        #1;
        check("b_rst_pc", pc_b, 32'h0);
        check("b_rst_inst", inst_b, 32'h0);
        check("b_rst_valid", {31'd0, valid_b}, 32'd0);
        check("b_rst_arvalid", {31'd0, arvalid_b}, 32'd0);
        check("b_rst_araddr", araddr_b, 32'hFFFF_FFFC);
        check("b_rst_rready", {31'd0, rready_b}, 32'd0);
        tick();                                    // 9
        stall_checks();
        rst_b = 0;
        tick();                                    // 10
        stall_checks();
        check("b_rel_arvalid", {31'd0, arvalid_b}, 32'd1);
        check("b_rel_araddr", araddr_b, 32'hFFFF_FFFC);
        repeat (2) begin                           // 11, 12
            tick();
            stall_checks();
        end
        stall_a = 0;
        #1;
        check("unstall_rready", {31'd0, rready_a}, 32'd1);
        tick();                                    // 13
        check("d3_pc", pc_a, 32'hC);
        check("d3_inst", inst_a, 32'hC0DE_000C);
        check("d3_valid", {31'd0, valid_a}, 32'd1);

        // Redirect while AR to 0x10 is held off by arready
        ar_wait = 3; redirect_a = 1; redirect_pc_a = 32'h100;
        tick();                                    // 14
        redirect_a = 0;
        check("redir_hold_addr0", araddr_a, 32'h10);
        check("redir_hold_valid", {31'd0, arvalid_a}, 32'd1);
        check("redir_kill_valid", {31'd0, valid_a}, 32'd0);
        tick();                                    // 15
        check("redir_hold_addr1", araddr_a, 32'h10);
        tick();                                    // 16
        check("redir_hold_addr2", araddr_a, 32'h10);
        tick();                                    // 17: AR 0x10 accepted
        tick();                                    // 18: stale beat
        check("redir_drop_valid", {31'd0, valid_a}, 32'd0);
        check("redir_next_addr", araddr_a, 32'h100);
        tick();                                    // 19
        tick();                                    // 20
        check("redir_pc", pc_a, 32'h100);
        check("redir_inst", inst_a, 32'hC0DE_0100);
        check("redir_valid", {31'd0, valid_a}, 32'd1);
        tick();                                    // 21

        // Redirect coinciding with the R beat; low bits of the target ignored
        redirect_a = 1; redirect_pc_a = 32'h203;
        tick();                                    // 22
        redirect_a = 0;
        check("same_drop_valid", {31'd0, valid_a}, 32'd0);
        check("same_next_addr", araddr_a, 32'h200);
        tick();                                    // 23
        tick();                                    // 24
        check("same_pc", pc_a, 32'h200);
        check("same_inst", inst_a, 32'hC0DE_0200);

        // Error response at 0x20
        ar_wait = 1; redirect_a = 1; redirect_pc_a = 32'h20;
        tick();                                    // 25
        redirect_a = 0;
        tick();                                    // 26
        tick();                                    // 27
        check("err_fetch_addr", araddr_a, 32'h20);
        tick();                                    // 28
        tick();                                    // 29
        check("err_inst", inst_a, 32'h0000_0013);
        check("err_pc", pc_a, 32'h20);
        check("err_valid", {31'd0, valid_a}, 32'd1);
        check("err_next_addr", araddr_a, 32'h24);
        tick();                                    // 30
        tick();                                    // 31
        check("post_err_pc", pc_a, 32'h24);
        check("post_err_inst", inst_a, 32'hC0DE_0024);

        check("ar_count", ar_log.size(), 32'd11);
        for (int i = 0; i < 11 && i < ar_log.size(); i++) begin
            check($sformatf("ar_seq%0d", i), ar_log[i], exp_log[i]);
        end

`ifdef IFU_STAT_EN
        check("fetch_cnt", fetch_cnt_a, 32'd8);
        check("drop_cnt", drop_cnt_a, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
